// File: rtl/inst_fetch.sv
// RV32I instruction fetch: PC, page-miss stall, 2-entry response FIFO, redirect flush.
// Optional: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects (sticky FETCH_ERR).
module inst_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        JUMP,
    input  logic [31:0] JUMP_PC,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_RDEN,
    input  logic [31:0] IMEM_OADDR,
    input  logic [31:0] IMEM_DOUT,
    input  logic        IMEM_VALID,
    input  logic        IMEM_LOADING,
    output logic        INST_VALID,
    input  logic        INST_READY,
    output logic [31:0] INST_PC,
    output logic [31:0] INST_DATA,
    output logic        FETCH_ERR
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OCC_W = 3;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

    logic [XLEN-1:0]  pc;
    fetch_entry_t     head_q;
    fetch_entry_t     tail_q;
    logic [1:0]       count;
    logic             inflight;
    logic             drop;
    logic             err;
    logic             deq;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occ;
    fetch_entry_t     resp;

    // Occupancy if this cycle's head leaves: FIFO entries plus the word still in flight.
    assign occ        = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(deq);
    assign INST_VALID = (count != 2'd0) && !JUMP;
    assign deq        = INST_VALID && INST_READY;
    assign IMEM_RDEN  = !RST && ENABLE && !JUMP && !err && (occ < OCC_W'(2));
    assign IMEM_ADDR  = pc;
    assign issue      = IMEM_RDEN && !IMEM_LOADING;
    assign push       = IMEM_VALID && !drop;
    assign resp       = '{pc: IMEM_OADDR, data: IMEM_DOUT};
    assign INST_PC    = head_q.pc;
    assign INST_DATA  = head_q.data;
    assign FETCH_ERR  = err;

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned redirect latches a sticky error that only reset clears.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err <= 1'b0;
        end else if (JUMP && (JUMP_PC[1:0] != 2'b00)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc       <= PC_RESET;
            count    <= 2'd0;
            inflight <= 1'b0;
            drop     <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
        end else if (JUMP) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (JUMP_PC[1:0] == 2'b00) begin
                pc <= JUMP_PC;
            end
`else
            pc <= JUMP_PC & 32'hFFFF_FFFC;
`endif
            count    <= 2'd0;
            drop     <= inflight;
            inflight <= 1'b0;
        end else begin
            drop     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                pc <= pc + 32'd4;
            end
            // Shift-register FIFO: head_q is always the oldest entry.
            case ({push, deq})
                2'b11: begin
                    if (count == 2'd1) begin
                        head_q <= resp;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= resp;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        head_q <= resp;
                    end else begin
                        tail_q <= resp;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    count  <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the RV32I core, upstream of the 4 KB page-cached instruction memory. Holds the PC, drives the memory's address/read-enable, stalls while the memory reports a page load, and absorbs the memory's 1-cycle read latency in a 2-entry FIFO. Delivers (PC, instruction) pairs to decode over a valid/ready handshake and accepts redirects from execute.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- ENABLE  in  1  fetch allowed; 0 holds PC and issues nothing
- JUMP  in  1  redirect request, single-cycle pulse
- JUMP_PC  in  32  redirect target
- IMEM_ADDR  out  32  fetch address (= PC register, combinational)
- IMEM_RDEN  out  1  read request this cycle
- IMEM_OADDR  in  32  address of returned word (1 cycle after request)
- IMEM_DOUT  in  32  returned instruction word
- IMEM_VALID  in  1  returned word valid
- IMEM_LOADING  in  1  memory busy filling page; request this cycle not accepted
- INST_VALID  out  1  FIFO head valid
- INST_READY  in  1  decode accepts head
- INST_PC  out  32  PC of head instruction
- INST_DATA  out  32  head instruction word
- FETCH_ERR  out  1  misaligned-redirect error (only with FETCH_MISALIGN_TRAP_EN)

## Operation
- Registers: pc[31:0], FIFO 2×64 bits with count[1:0], inflight (1 bit), drop (1 bit), err (1 bit).
- Reset values: pc=PC_RESET, count=0, inflight=0, drop=0, err=0; hence IMEM_RDEN=0, INST_VALID=0, FETCH_ERR=0, INST_PC/INST_DATA=0.
- deq = INST_VALID && INST_READY. INST_VALID = (count!=0) && !JUMP.
- IMEM_RDEN = ENABLE && !JUMP && !err && (count + inflight − deq < 2).
- Issue accepted when IMEM_RDEN && !IMEM_LOADING: pc <= pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0), inflight <= 1; otherwise inflight <= 0, pc holds.
- IMEM_RDEN stays asserted through LOADING with IMEM_ADDR unchanged until the page is loaded; no separate state needed.
- Response: if IMEM_VALID && !drop, push {IMEM_OADDR, IMEM_DOUT}. The issue rule guarantees no push into a full FIFO; push and deq in the same cycle leaves count unchanged.
- JUMP cycle: pc <= JUMP_PC, count <= 0, drop <= inflight (discards the one response still in flight), inflight <= 0; no issue, no dequeue. drop clears after one cycle.
- Simultaneous JUMP with IMEM_VALID: the returning word is discarded.
- ENABLE low mid-stream: in-flight response is still pushed; FIFO drains normally.

## Timing
- Request at cycle N (accepted) -> IMEM_VALID at N+1 -> INST_VALID at N+2 when the FIFO was empty (pass-through not supported).
- Steady state with INST_READY=1: one instruction per cycle.
- Redirect: JUMP at cycle N -> first request at JUMP_PC in N+1 -> INST_VALID at N+3 (page hit).
- INST_READY low: FIFO fills to 2 and then IMEM_RDEN falls; no data lost, no duplicates.
- RST asserted mid-operation clears all state immediately, independent of CLK.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: JUMP with JUMP_PC[1:0]!=0 sets err (sticky until RST); pc is not updated, FIFO still flushes, FETCH_ERR=err, IMEM_RDEN held 0.
- Not defined: pc <= {JUMP_PC[31:2], 2'b00}; FETCH_ERR tied 0; err register absent.

## Test plan
- Reset, ENABLE=1, memory hits, INST_READY=1 -> INST_PC 0x0,0x4,0x8,… one per cycle from cycle 2; data matches memory words.
- Page miss: IMEM_LOADING=1 for 40 cycles at PC 0x1000 -> IMEM_ADDR held 0x1000, PC not advanced, first INST_PC=0x1000 two cycles after LOADING drops.
- INST_READY=0 for 10 cycles -> count saturates at 2, IMEM_RDEN=0; on release, PCs resume consecutive with no gap or repeat.
- JUMP to 0x2040 while one word in flight and FIFO holding 2 -> both FIFO entries and the in-flight word discarded; next INST_PC=0x2040 three cycles later.
- PC at 0xFFFF_FFFC -> next INST_PC=0x0000_0000.
- JUMP to 0x2042: with macro -> FETCH_ERR=1, IMEM_RDEN=0 until RST; without -> fetch resumes at 0x2040.
